experiment_top_level_wrapper: RTL and testbench

Top-level control/data wrapper of the optical Ising-machine experiment. It owns:
- a GPIO byte-write register interface;
- output-scaler LUTs (A, A-NL, B, C) and input-driver LUTs (MAC, NL);
- A/C vector FIFOs;
- instruction and B memories loaded over a CPU DMA AXI-Stream;
- a run-control FSM that streams 16-lane DAC words and converts ADC samples through LUTs.

---
 rtl/experiment_top_level_wrapper.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_experiment_top_level_wrapper.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/experiment_top_level_wrapper.sv
// Control/data wrapper of the optical Ising-machine experiment: GPIO byte registers,
// scaler/driver LUTs, A/C FIFOs, DMA-loaded memories, run FSM, DAC streaming and ADC lookup.
module experiment_top_level_wrapper #(
    parameter int unsigned LANES      = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           gpio_in,
    output logic [31:0]           gpio_out_bus,
    output logic [LANES*16-1:0]   m0_axis_tdata,
    output logic                  m0_axis_tvalid,
    input  logic                  m0_axis_tready,
    output logic [LANES*16-1:0]   m1_axis_tdata,
    output logic                  m1_axis_tvalid,
    input  logic                  m1_axis_tready,
    output logic [LANES*16-1:0]   m2_axis_tdata,
    output logic                  m2_axis_tvalid,
    input  logic                  m2_axis_tready,
    output logic [LANES*16-1:0]   m3_axis_tdata,
    output logic                  m3_axis_tvalid,
    input  logic                  m3_axis_tready,
    input  logic [LANES*8-1:0]    s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic [LANES*8-1:0]    s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic [15:0]           s2_axis_tdata,
    input  logic                  s2_axis_tvalid,
    output logic                  s2_axis_tready
);
    localparam int unsigned DW       = 16;
    localparam int unsigned FAW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW       = FAW + 1;
    localparam int unsigned MAW      = $clog2(MEM_DEPTH);
    localparam int unsigned SLW      = 8;
    localparam int unsigned SL_DEPTH = 1 << SLW;
    localparam int unsigned DLW      = 16;
    localparam int unsigned DL_DEPTH = 1 << DLW;

    localparam logic [15:0] ADDR_A_WR   = 16'h0000;
    localparam logic [15:0] ADDR_C_WR   = 16'h0001;
    localparam logic [15:0] ADDR_A_RD   = 16'h0002;
    localparam logic [15:0] ADDR_C_RD   = 16'h0003;
    localparam logic [15:0] ADDR_IB_SEL = 16'h0004;
    localparam logic [15:0] ADDR_RUN    = 16'h0005;
    localparam logic [15:0] ADDR_HALT   = 16'h0006;
    localparam logic [15:0] ADDR_A_PTR  = 16'h0010;
    localparam logic [15:0] ADDR_A_DAT  = 16'h0011;
    localparam logic [15:0] ADDR_AN_PTR = 16'h0012;
    localparam logic [15:0] ADDR_AN_DAT = 16'h0013;
    localparam logic [15:0] ADDR_B_PTR  = 16'h0014;
    localparam logic [15:0] ADDR_B_DAT  = 16'h0015;
    localparam logic [15:0] ADDR_C_PTR  = 16'h0016;
    localparam logic [15:0] ADDR_C_DAT  = 16'h0017;
    localparam logic [15:0] ADDR_M_PTR  = 16'h0018;
    localparam logic [15:0] ADDR_M_DAT  = 16'h0019;
    localparam logic [15:0] ADDR_N_PTR  = 16'h001A;
    localparam logic [15:0] ADDR_N_DAT  = 16'h001B;
    localparam logic [15:0] ADDR_M_RES  = 16'h001C;
    localparam logic [15:0] ADDR_N_RES  = 16'h001D;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_LOAD     = 3'd2,
        ST_RUN      = 3'd3,
        ST_WAIT_RST = 3'd4
    } ex_state_t;

    logic [15:0]    g_addr;
    logic [7:0]     g_data;
    logic           w_clk, w_prev, wr_stb, two_byte, wr_word;
    logic [4:0]     reg_idx;
    logic [31:0]    phase;
    logic [7:0]     hi_byte [32];
    logic [DW-1:0]  word;
    logic [15:0]    read_sel;
    logic [DW-1:0]  rdata;
    logic           b_sel, run_trig, halt;
    logic [SLW-1:0] a_ptr, an_ptr, bl_ptr, cl_ptr;
    logic [DLW-1:0] mac_ptr, nl_ptr;

    logic [DW-1:0]  a_lut [SL_DEPTH];
    logic [DW-1:0]  an_lut [SL_DEPTH];
    logic [DW-1:0]  bl_lut [SL_DEPTH];
    logic [DW-1:0]  cl_lut [SL_DEPTH];
    logic [DW-1:0]  mac_lut [DL_DEPTH];
    logic [DW-1:0]  nl_lut [DL_DEPTH];
    logic [DW-1:0]  instr_mem [MEM_DEPTH];
    logic [DW-1:0]  b_mem [MEM_DEPTH];

    logic [DW-1:0]  a_fifo [FIFO_DEPTH];
    logic [DW-1:0]  c_fifo [FIFO_DEPTH];
    logic [FAW-1:0] a_wp, a_rp, c_wp, c_rp;
    logic [CW-1:0]  a_cnt, c_cnt;
    logic           a_push, c_push, a_pop, c_pop, a_rd, c_rd;
    logic [DW-1:0]  a_head, c_head;

    logic [MAW-1:0] instr_wp, b_wp, k;
    logic [MAW:0]   k_inc;
    logic [DW-1:0]  b_cur, instr_cur;
    logic           all_ready, dac_load;
    ex_state_t      ex_state;

    logic           mac_v, nl_v;
    logic [DLW-1:0] mac_idx, nl_idx;
    logic [DW-1:0]  mac_result, nl_result;

    assign s0_axis_tready = 1'b1;
    assign s1_axis_tready = 1'b1;
    assign s2_axis_tready = 1'b1;

    // GPIO decode: a write fires on the rising edge of the sampled w_clk bit
    always_comb begin
        g_addr   = gpio_in[15:0];
        g_data   = gpio_in[23:16];
        w_clk    = gpio_in[24];
        wr_stb   = w_clk & ~w_prev;
        reg_idx  = g_addr[4:0];
        two_byte = (g_addr[15:1] == 15'h0) || ((g_addr >= ADDR_A_PTR) && (g_addr <= ADDR_N_DAT));
        wr_word  = wr_stb & two_byte & phase[reg_idx];
        word     = {hi_byte[reg_idx], g_data};
    end

    always_comb begin
        a_push    = wr_word && (g_addr == ADDR_A_WR) && (a_cnt != CW'(FIFO_DEPTH));
        c_push    = wr_word && (g_addr == ADDR_C_WR) && (c_cnt != CW'(FIFO_DEPTH));
        a_rd      = wr_stb && (g_addr == ADDR_A_RD);
        c_rd      = wr_stb && (g_addr == ADDR_C_RD);
        a_pop     = a_rd && (a_cnt != '0);
        c_pop     = c_rd && (c_cnt != '0);
        a_head    = (a_cnt != '0) ? a_fifo[a_rp] : '0;
        c_head    = (c_cnt != '0) ? c_fifo[c_rp] : '0;
        b_cur     = b_mem[k];
        instr_cur = instr_mem[k];
        k_inc     = {1'b0, k} + 1'b1;
        all_ready = m0_axis_tready & m1_axis_tready & m2_axis_tready & m3_axis_tready;
        dac_load  = ~m0_axis_tvalid | all_ready;
    end

    // Register file: phase flags, pointers and control bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_prev   <= 1'b0;
            phase    <= '0;
            for (int i = 0; i < 32; i++) hi_byte[i] <= '0;
            read_sel <= '0;
            b_sel    <= 1'b0;
            run_trig <= 1'b0;
            halt     <= 1'b0;
            a_ptr    <= '0;
            an_ptr   <= '0;
            bl_ptr   <= '0;
            cl_ptr   <= '0;
            mac_ptr  <= '0;
            nl_ptr   <= '0;
        end else begin
            w_prev <= w_clk;
            if (wr_stb) begin
                read_sel <= g_addr;
                if (two_byte) begin
                    phase[reg_idx] <= ~phase[reg_idx];
                    if (!phase[reg_idx]) hi_byte[reg_idx] <= g_data;
                end
                case (g_addr)
                    ADDR_IB_SEL: b_sel    <= g_data[0];
                    ADDR_RUN:    run_trig <= g_data[0];
                    ADDR_HALT:   halt     <= g_data[0];
                    default: ;
                endcase
            end
            if (wr_word) begin
                case (g_addr)
                    ADDR_A_PTR:  begin a_ptr   <= word[SLW-1:0]; phase[5'h11] <= 1'b0; end
                    ADDR_AN_PTR: begin an_ptr  <= word[SLW-1:0]; phase[5'h13] <= 1'b0; end
                    ADDR_B_PTR:  begin bl_ptr  <= word[SLW-1:0]; phase[5'h15] <= 1'b0; end
                    ADDR_C_PTR:  begin cl_ptr  <= word[SLW-1:0]; phase[5'h17] <= 1'b0; end
                    ADDR_M_PTR:  begin mac_ptr <= word;          phase[5'h19] <= 1'b0; end
                    ADDR_N_PTR:  begin nl_ptr  <= word;          phase[5'h1B] <= 1'b0; end
                    ADDR_A_DAT:  a_ptr   <= a_ptr + 1'b1;
                    ADDR_AN_DAT: an_ptr  <= an_ptr + 1'b1;
                    ADDR_B_DAT:  bl_ptr  <= bl_ptr + 1'b1;
                    ADDR_C_DAT:  cl_ptr  <= cl_ptr + 1'b1;
                    ADDR_M_DAT:  mac_ptr <= mac_ptr + 1'b1;
                    ADDR_N_DAT:  nl_ptr  <= nl_ptr + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Storage arrays carry no reset
    always_ff @(posedge clk) begin
        if (wr_word) begin
            case (g_addr)
                ADDR_A_DAT:  a_lut[a_ptr]     <= word;
                ADDR_AN_DAT: an_lut[an_ptr]   <= word;
                ADDR_B_DAT:  bl_lut[bl_ptr]   <= word;
                ADDR_C_DAT:  cl_lut[cl_ptr]   <= word;
                ADDR_M_DAT:  mac_lut[mac_ptr] <= word;
                ADDR_N_DAT:  nl_lut[nl_ptr]   <= word;
                default: ;
            endcase
        end
        if (a_push) a_fifo[a_wp] <= word;
        if (c_push) c_fifo[c_wp] <= word;
        if (s2_axis_tvalid) begin
            if (b_sel) b_mem[b_wp] <= s2_axis_tdata;
            else       instr_mem[instr_wp] <= s2_axis_tdata;
        end
    end

    // A/C FIFO pointers and the shared read-back register
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_wp  <= '0;
            a_rp  <= '0;
            a_cnt <= '0;
            c_wp  <= '0;
            c_rp  <= '0;
            c_cnt <= '0;
            rdata <= '0;
        end else begin
            if (a_push) begin a_wp <= a_wp + 1'b1; a_cnt <= a_cnt + 1'b1; end
            if (c_push) begin c_wp <= c_wp + 1'b1; c_cnt <= c_cnt + 1'b1; end
            if (a_pop)  begin a_rp <= a_rp + 1'b1; a_cnt <= a_cnt - 1'b1; end
            if (c_pop)  begin c_rp <= c_rp + 1'b1; c_cnt <= c_cnt - 1'b1; end
            if (a_rd) rdata <= a_head;
            if (c_rd) rdata <= c_head;
        end
    end

    // DMA write pointers; a target select write restarts that memory at 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_wp <= '0;
            b_wp     <= '0;
        end else if (wr_stb && (g_addr == ADDR_IB_SEL)) begin
            if (g_data[0]) b_wp <= '0;
            else           instr_wp <= '0;
        end else if (s2_axis_tvalid) begin
            if (b_sel) b_wp <= b_wp + 1'b1;
            else       instr_wp <= instr_wp + 1'b1;
        end
    end

    // Run FSM and DAC streaming; the output beat is held until all four sinks accept
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_state       <= ST_IDLE;
            k              <= '0;
            m0_axis_tvalid <= 1'b0;
            m1_axis_tvalid <= 1'b0;
            m2_axis_tvalid <= 1'b0;
            m3_axis_tvalid <= 1'b0;
            m0_axis_tdata  <= '0;
            m1_axis_tdata  <= '0;
            m2_axis_tdata  <= '0;
            m3_axis_tdata  <= '0;
        end else begin
            case (ex_state)
                ST_IDLE:     if (run_trig) ex_state <= ST_ARM;
                ST_ARM:      ex_state <= halt ? ST_WAIT_RST : ST_LOAD;
                ST_LOAD: begin
                    k        <= '0;
                    ex_state <= halt ? ST_WAIT_RST : ST_RUN;
                end
                ST_RUN:      if (halt) ex_state <= ST_WAIT_RST;
                ST_WAIT_RST: if (!run_trig && !halt) ex_state <= ST_IDLE;
                default:     ex_state <= ST_IDLE;
            endcase
            if (ex_state == ST_RUN) begin
                if (dac_load) begin
                    m0_axis_tvalid <= 1'b1;
                    m1_axis_tvalid <= 1'b1;
                    m2_axis_tvalid <= 1'b1;
                    m3_axis_tvalid <= 1'b1;
                    m0_axis_tdata  <= {LANES{a_lut[a_head[SLW-1:0]]}};
                    m3_axis_tdata  <= {LANES{an_lut[a_head[SLW-1:0]]}};
                    m1_axis_tdata  <= {LANES{bl_lut[b_cur[SLW-1:0]]}};
                    m2_axis_tdata  <= {LANES{cl_lut[c_head[SLW-1:0]]}};
                    if ((instr_wp == '0) || (k_inc >= {1'b0, instr_wp})) k <= '0;
                    else k <= k_inc[MAW-1:0];
                end
            end else begin
                m0_axis_tvalid <= 1'b0;
                m1_axis_tvalid <= 1'b0;
                m2_axis_tvalid <= 1'b0;
                m3_axis_tvalid <= 1'b0;
                m0_axis_tdata  <= '0;
                m1_axis_tdata  <= '0;
                m2_axis_tdata  <= '0;
                m3_axis_tdata  <= '0;
            end
        end
    end

    // ADC conversion (two-stage) and live read-back mux
    always_ff @(posedge clk) begin
        if (!rst) begin
            mac_v        <= 1'b0;
            nl_v         <= 1'b0;
            mac_idx      <= '0;
            nl_idx       <= '0;
            mac_result   <= '0;
            nl_result    <= '0;
            gpio_out_bus <= '0;
        end else begin
            mac_v <= s0_axis_tvalid;
            nl_v  <= s1_axis_tvalid;
            if (s0_axis_tvalid) mac_idx <= s0_axis_tdata[DLW-1:0];
            if (s1_axis_tvalid) nl_idx  <= s1_axis_tdata[DLW-1:0];
            if (mac_v) mac_result <= mac_lut[mac_idx];
            if (nl_v)  nl_result  <= nl_lut[nl_idx];
            case (read_sel)
                ADDR_A_RD, ADDR_C_RD: gpio_out_bus <= {16'b0, rdata};
                ADDR_M_RES:           gpio_out_bus <= {16'b0, mac_result};
                ADDR_N_RES:           gpio_out_bus <= {16'b0, nl_result};
                default:              gpio_out_bus <= {29'b0, ex_state};
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{gpio_in[31:25], s0_axis_tdata[LANES*8-1:DLW], s1_axis_tdata[LANES*8-1:DLW],
                           a_head[DW-1:SLW], c_head[DW-1:SLW], b_cur[DW-1:SLW], instr_cur};

endmodule

// File: tb/tb_experiment_top_level_wrapper.sv
// Scoreboard bench for experiment_top_level_wrapper: stimulus queues expectations,
// a negedge monitor compares GPIO read-back, tvalid state and DAC handshake beats.
module tb_experiment_top_level_wrapper;
    localparam int unsigned LANES = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out_bus;
    logic [LANES*16-1:0] m0_tdata, m1_tdata, m2_tdata, m3_tdata;
    logic m0_tvalid, m1_tvalid, m2_tvalid, m3_tvalid;
    logic m0_rdy = 1'b1, m1_rdy = 1'b1, m2_rdy = 1'b1, m3_rdy = 1'b1;
    logic [LANES*8-1:0] s0_tdata = '0, s1_tdata = '0;
    logic s0_tvalid = 1'b0, s1_tvalid = 1'b0, s0_tready, s1_tready;
    logic [15:0] s2_tdata = '0;
    logic s2_tvalid = 1'b0, s2_tready;

    experiment_top_level_wrapper dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .gpio_out_bus(gpio_out_bus),
        .m0_axis_tdata(m0_tdata), .m0_axis_tvalid(m0_tvalid), .m0_axis_tready(m0_rdy),
        .m1_axis_tdata(m1_tdata), .m1_axis_tvalid(m1_tvalid), .m1_axis_tready(m1_rdy),
        .m2_axis_tdata(m2_tdata), .m2_axis_tvalid(m2_tvalid), .m2_axis_tready(m2_rdy),
        .m3_axis_tdata(m3_tdata), .m3_axis_tvalid(m3_tvalid), .m3_axis_tready(m3_rdy),
        .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
        .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
        .s2_axis_tdata(s2_tdata), .s2_axis_tvalid(s2_tvalid), .s2_axis_tready(s2_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        obs_q[$];
    logic [15:0] strm_q[$];
    logic        obs_req = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    logic [15:0] exp_m0 = '0, exp_m2 = '0, exp_m3 = '0;
    logic [15:0] bval [9];
    exp_t        mon_ent;
    logic [15:0] mon_beat;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: register observations on request, DAC beats on every handshake
    always @(negedge clk) begin
        if (obs_req) begin
            if (obs_q.size() == 0) begin
                check("obs_queue_empty", 256'd1, 256'd0);
            end else begin
                mon_ent = obs_q.pop_front();
                case (mon_ent.sel)
                    0: check(mon_ent.name, {224'b0, gpio_out_bus}, {224'b0, mon_ent.val});
                    1: check(mon_ent.name, {252'b0, m0_tvalid, m1_tvalid, m2_tvalid, m3_tvalid},
                             {224'b0, mon_ent.val});
                    default: check(mon_ent.name, {240'b0, m1_tdata[15:0]}, {224'b0, mon_ent.val});
                endcase
            end
        end
        if (m0_tvalid && m0_rdy && m1_rdy && m2_rdy && m3_rdy) begin
            hs_count++;
            if (strm_q.size() != 0) begin
                mon_beat = strm_q.pop_front();
                check("m1_beat", m1_tdata, {LANES{mon_beat}});
                check("m0_beat", m0_tdata, {LANES{exp_m0}});
                check("m2_beat", m2_tdata, {LANES{exp_m2}});
                check("m3_beat", m3_tdata, {LANES{exp_m3}});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gpio_write(input logic [15:0] a, input logic [7:0] d);
        gpio_in = {8'h00, d, a};
        tick();
        gpio_in[24] = 1'b1;
        tick();
        gpio_in[24] = 1'b0;
        tick();
    endtask

    task automatic write16(input logic [15:0] a, input logic [15:0] v);
        gpio_write(a, v[15:8]);
        gpio_write(a, v[7:0]);
    endtask

    task automatic expect_obs(input string n, input int s, input logic [31:0] v);
        exp_t ent;
        ent.name = n;
        ent.sel  = s;
        ent.val  = v;
        obs_q.push_back(ent);
        obs_req = 1'b1;
        tick();
        obs_req = 1'b0;
    endtask

    task automatic s2_beat(input logic [15:0] v);
        s2_tdata  = v;
        s2_tvalid = 1'b1;
        tick();
        s2_tvalid = 1'b0;
    endtask

    task automatic drain(input string n);
        for (int i = 0; i < 200 && strm_q.size() != 0; i++) tick();
        checks++;
        if (strm_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d beats pending, required 0", n, strm_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        for (int i = 0; i < 9; i++) bval[i] = 16'(i * 7 + 3);

        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        expect_obs("reset_gpio", 0, 32'h0);
        expect_obs("reset_tvalid", 1, 32'h0);

        // FIFO round trips
        for (int i = 0; i < 16; i++) write16(16'h0000, 16'(i));
        for (int i = 0; i < 16; i++) begin
            gpio_write(16'h0002, 8'h00);
            expect_obs("a_fifo_rd", 0, 32'(i));
        end
        for (int i = 16; i < 32; i++) write16(16'h0001, 16'(i));
        for (int i = 16; i < 32; i++) begin
            gpio_write(16'h0003, 8'h00);
            expect_obs("c_fifo_rd", 0, 32'(i));
        end
        gpio_write(16'h0002, 8'h00);
        expect_obs("a_fifo_empty", 0, 32'h0);
        gpio_write(16'h0003, 8'h00);
        expect_obs("c_fifo_empty", 0, 32'h0);

        // Scaler LUTs and memories
        write16(16'h0010, 16'h0000);
        for (int n = 0; n < 256; n++) write16(16'h0011, 16'(n));
        write16(16'h0014, 16'h0000);
        for (int n = 0; n < 256; n++) write16(16'h0015, 16'(16'h1000 + n));
        write16(16'h0012, 16'h0005);
        write16(16'h0013, 16'hA5A5);
        write16(16'h0016, 16'h0000);
        write16(16'h0017, 16'h0C0C);
        gpio_write(16'h0004, 8'h01);
        for (int i = 0; i < 9; i++) s2_beat(bval[i]);
        gpio_write(16'h0004, 8'h00);
        for (int i = 0; i < 8; i++) s2_beat(16'(16'hF000 + i));
        write16(16'h0000, 16'h0005);

        // Run and stream
        exp_m0 = 16'h0005;
        exp_m2 = 16'h0C0C;
        exp_m3 = 16'hA5A5;
        for (int j = 0; j < 20; j++) strm_q.push_back(16'(16'h1000 + bval[j % 8]));
        gpio_write(16'h0005, 8'h01);
        tick();
        expect_obs("ex_state_arm", 0, 32'h1);
        repeat (100) tick();
        expect_obs("ex_state_run", 0, 32'h3);
        drain("stream_run");

        // Backpressure: held beat must stay put, then resume in order
        m1_rdy = 1'b0;
        idx = hs_count % 8;
        for (int i = 0; i < 8; i++) expect_obs("stall_m1", 2, 32'(16'h1000 + bval[idx]));
        for (int j = 0; j < 16; j++) strm_q.push_back(16'(16'h1000 + bval[(idx + j) % 8]));
        m1_rdy = 1'b1;
        drain("stream_resume");

        // Halt and return to idle
        gpio_write(16'h0006, 8'h01);
        tick();
        expect_obs("ex_state_halt", 0, 32'h4);
        expect_obs("halt_tvalid", 1, 32'h0);
        gpio_write(16'h0006, 8'h00);
        gpio_write(16'h0005, 8'h00);
        tick();
        expect_obs("ex_state_idle", 0, 32'h0);

        // ADC lookups
        write16(16'h0018, 16'h1233);
        write16(16'h0019, 16'h1233 ^ 16'hFFFF);
        write16(16'h0019, 16'h1234 ^ 16'hFFFF);
        write16(16'h0019, 16'h1235 ^ 16'hFFFF);
        write16(16'h001A, 16'h8000);
        write16(16'h001B, 16'h7777);
        s0_tdata[15:0] = 16'h1234;
        s1_tdata[15:0] = 16'h8000;
        s0_tvalid = 1'b1;
        s1_tvalid = 1'b1;
        tick();
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        repeat (3) tick();
        gpio_write(16'h001C, 8'h00);
        expect_obs("mac_result", 0, 32'h0000EDCB);
        gpio_write(16'h001D, 8'h00);
        expect_obs("nl_result", 0, 32'h00007777);
        s0_tdata[15:0] = 16'h1235;
        s0_tvalid = 1'b1;
        tick();
        s0_tvalid = 1'b0;
        repeat (3) tick();
        gpio_write(16'h001C, 8'h00);
        expect_obs("mac_result_next", 0, 32'h0000EDCA);

        // C FIFO overflow: the 65th push is dropped
        for (int i = 0; i < 65; i++) write16(16'h0001, 16'(200 + i));
        for (int i = 0; i < 64; i++) begin
            gpio_write(16'h0003, 8'h00);
            expect_obs("c_full_rd", 0, 32'(200 + i));
        end
        gpio_write(16'h0003, 8'h00);
        expect_obs("c_full_drop", 0, 32'h0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
